// File: rtl/pc_ctrl.sv
// Program-counter and branch-control stage: steps the fetch PC, redirects taken
// beq through a writable target table, and runs the start/halt/done handshake.
module pc_ctrl #(
    parameter int PC_W       = 10,
    parameter int LUT_AW     = 4,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic              zero_i,
    input  logic              halt_i,
    input  logic [LUT_AW-1:0] lut_idx_i,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
    output logic [PC_W-1:0]   pc_o,
    output logic              running_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  cycles_o,
    output logic              taken_o
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [CNT_W-1:0]  cycles_q;
    logic              running_q;
    logic              done_q;
    logic              taken_q;
    logic [PC_W-1:0]   lut_q [2**LUT_AW];

    logic [CNT_W-1:0]  cycles_d;
    logic [PC_W-1:0]   target_d;

    // Saturating increment; the run counter never wraps back to zero.
    always_comb begin
        cycles_d = cycles_q;
        if (cycles_q != '1) begin
            cycles_d = cycles_q + 1'b1;
        end
    end

    // Read happens before this edge's write lands, so a same-index write is seen next cycle.
    always_comb begin
        target_d = lut_q[lut_idx_i];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= START_PC;
            cycles_q  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            taken_q   <= 1'b0;
            for (int unsigned i = 0; i < 2**LUT_AW; i++) begin
                lut_q[LUT_AW'(i)] <= '0;
            end
        end else begin
            if (lut_we) begin
                lut_q[lut_waddr] <= lut_wdata;
            end
            taken_q <= 1'b0;
            unique case (state_q)
                IDLE, HALTED: begin
                    if (start) begin
                        state_q   <= RUN;
                        pc_q      <= START_PC;
                        cycles_q  <= '0;
                        running_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                RUN: begin
                    if (start) begin
                        pc_q     <= START_PC;
                        cycles_q <= '0;
                    end else if (stall_i) begin
                        pc_q <= pc_q;
                    end else if (halt_i) begin
                        state_q   <= HALTED;
                        cycles_q  <= cycles_d;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end else if (branch_i && zero_i) begin
                        pc_q     <= target_d;
                        cycles_q <= cycles_d;
                        taken_q  <= 1'b1;
                    end else begin
                        pc_q     <= pc_q + 1'b1;
                        cycles_q <= cycles_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pc_o      = pc_q;
    assign running_o = running_q;
    assign done_o    = done_q;
    assign cycles_o  = cycles_q;
    assign taken_o   = taken_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// Bench for pc_ctrl: a full-size and a narrow instance share stimulus and are
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_pc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, start, stall, branch, zero, halt, we;
    logic [3:0] idx, waddr;
    logic [9:0] wdata;

    logic [9:0]  pc_b;
    logic        run_b, done_b, tak_b;
    logic [15:0] cyc_b;
    logic [3:0]  pc_s;
    logic        run_s, done_s, tak_s;
    logic [2:0]  cyc_s;

    int total = 0;
    int bad   = 0;

    // Model state per instance: 0 = full size, 1 = narrow (PC 4b, LUT 2b, count 3b).
    int m_st  [2];
    int m_pc  [2];
    int m_cyc [2];
    int m_tak [2];
    int m_lut [2][16];

    always #5 clk = ~clk;

    pc_ctrl #(.PC_W(10), .LUT_AW(4), .START_ADDR(0), .CNT_W(16)) u_big (
        .clk(clk), .rst_n(rst_n), .start(start), .stall_i(stall),
        .branch_i(branch), .zero_i(zero), .halt_i(halt), .lut_idx_i(idx),
        .lut_we(we), .lut_waddr(waddr), .lut_wdata(wdata),
        .pc_o(pc_b), .running_o(run_b), .done_o(done_b),
        .cycles_o(cyc_b), .taken_o(tak_b)
    );

    pc_ctrl #(.PC_W(4), .LUT_AW(2), .START_ADDR(0), .CNT_W(3)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start), .stall_i(stall),
        .branch_i(branch), .zero_i(zero), .halt_i(halt), .lut_idx_i(idx[1:0]),
        .lut_we(we), .lut_waddr(waddr[1:0]), .lut_wdata(wdata[3:0]),
        .pc_o(pc_s), .running_o(run_s), .done_o(done_s),
        .cycles_o(cyc_s), .taken_o(tak_s)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int pw, aw, cw, nxt, old_tgt;
        pw = (k == 0) ? 10 : 4;
        aw = (k == 0) ? 4 : 2;
        cw = (k == 0) ? 16 : 3;
        if (!rst_n) begin
            m_st[k] = 0; m_pc[k] = 0; m_cyc[k] = 0; m_tak[k] = 0;
            for (int i = 0; i < 16; i++) m_lut[k][i] = 0;
            return;
        end
        old_tgt  = m_lut[k][int'(idx) % (1 << aw)];
        m_tak[k] = 0;
        if (m_st[k] != 1) begin
            if (start) begin m_st[k] = 1; m_pc[k] = 0; m_cyc[k] = 0; end
        end else if (start) begin
            m_pc[k] = 0; m_cyc[k] = 0;
        end else if (!stall) begin
            nxt = (m_pc[k] + 1) % (1 << pw);
            if (halt) m_st[k] = 2;
            else if (branch && zero) begin nxt = old_tgt; m_tak[k] = 1; end
            if (!halt) m_pc[k] = nxt;
            if (m_cyc[k] < (1 << cw) - 1) m_cyc[k] = m_cyc[k] + 1;
        end
        if (we) m_lut[k][int'(waddr) % (1 << aw)] = int'(wdata) % (1 << pw);
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
        #1;
        check("pc_big",   int'(pc_b),   m_pc[0]);
        check("run_big",  int'(run_b),  int'(m_st[0] == 1));
        check("done_big", int'(done_b), int'(m_st[0] == 2));
        check("cyc_big",  int'(cyc_b),  m_cyc[0]);
        check("tak_big",  int'(tak_b),  m_tak[0]);
        check("pc_sm",    int'(pc_s),   m_pc[1]);
        check("run_sm",   int'(run_s),  int'(m_st[1] == 1));
        check("done_sm",  int'(done_s), int'(m_st[1] == 2));
        check("cyc_sm",   int'(cyc_s),  m_cyc[1]);
        check("tak_sm",   int'(tak_s),  m_tak[1]);
    end

    task automatic idle();
        start = 0; stall = 0; branch = 0; zero = 0; halt = 0;
        we = 0; idx = '0; waddr = '0; wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        tick(); tick();
        check("rst_pc", int'(pc_b), 0);
        check("rst_run", int'(run_b), 0);
        check("rst_done", int'(done_b), 0);
        check("rst_cyc", int'(cyc_b), 0);
        check("rst_tak", int'(tak_b), 0);

        rst_n = 1'b1;
        go();
        check("start_pc", int'(pc_b), 0);
        check("start_run", int'(run_b), 1);
        repeat (5) tick();
        check("seq_pc", int'(pc_b), 5);
        check("seq_cyc", int'(cyc_b), 5);
        check("seq_done", int'(done_b), 0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("midrst_pc", int'(pc_b), 0);
        check("midrst_run", int'(run_b), 0);

        we = 1; waddr = 4'd3; wdata = 10'h120; tick(); we = 0;
        go(); repeat (7) tick();
        check("pre_br_pc", int'(pc_b), 7);
        branch = 1; zero = 1; idx = 4'd3; tick(); branch = 0; zero = 0;
        check("br_pc", int'(pc_b), 'h120);
        check("br_tak", int'(tak_b), 1);
        tick();
        check("br_tak_clr", int'(tak_b), 0);
        check("br_next_pc", int'(pc_b), 'h121);

        go(); repeat (7) tick();
        branch = 1; zero = 0; idx = 4'd3; tick(); branch = 0;
        check("nt_pc", int'(pc_b), 8);
        check("nt_tak", int'(tak_b), 0);

        go(); repeat (7) tick();
        branch = 1; zero = 1; idx = 4'd3; we = 1; waddr = 4'd3; wdata = 10'h055;
        tick(); we = 0;
        check("wr_old_pc", int'(pc_b), 'h120);
        tick();
        check("wr_new_pc", int'(pc_b), 'h055);
        idle();

        go();
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 10) check("sat_cyc10", int'(cyc_s), 7);
            if (i == 14) check("wrap_e", int'(pc_s), 'hE);
            if (i == 15) check("wrap_f", int'(pc_s), 'hF);
            if (i == 16) check("wrap_0", int'(pc_s), 0);
            if (i == 17) check("wrap_1", int'(pc_s), 1);
        end
        check("sat_cyc17", int'(cyc_s), 7);

        go(); repeat (16) tick();
        check("pre_halt_pc", int'(pc_b), 'h10);
        halt = 1; branch = 1; zero = 1; idx = 4'd3; tick(); idle();
        check("halt_done", int'(done_b), 1);
        check("halt_pc", int'(pc_b), 'h10);
        check("halt_run", int'(run_b), 0);
        check("halt_cyc", int'(cyc_b), 17);
        tick();
        check("halt_hold", int'(pc_b), 'h10);
        go();
        check("rs_pc", int'(pc_b), 0);
        check("rs_done", int'(done_b), 0);
        check("rs_cyc", int'(cyc_b), 0);

        repeat (4) tick();
        stall = 1; branch = 1; zero = 1; halt = 1; idx = 4'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", int'(pc_b), 4);
            check("stall_cyc", int'(cyc_b), 4);
            check("stall_done", int'(done_b), 0);
        end
        stall = 0; halt = 0; tick(); idle();
        check("unstall_pc", int'(pc_b), 'h055);
        check("unstall_tak", int'(tak_b), 1);
        check("unstall_cyc", int'(cyc_b), 5);

        for (int n = 0; n < 3000; n++) begin
            rst_n  = ($urandom_range(0, 99) != 0);
            start  = ($urandom_range(0, 99) < 3);
            stall  = ($urandom_range(0, 99) < 20);
            branch = ($urandom_range(0, 99) < 35);
            zero   = ($urandom_range(0, 1) == 1);
            halt   = ($urandom_range(0, 99) < 3);
            idx    = 4'($urandom_range(0, 15));
            we     = ($urandom_range(0, 99) < 20);
            waddr  = 4'($urandom_range(0, 15));
            wdata  = 10'($urandom);
            tick();
        end
        idle();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Program-counter and branch-control stage that consumes the execute stage's `zero` flag and drives the instruction-fetch address. It holds the PC, steps it each cycle, redirects on a taken `beq` through a writable branch-target lookup table, and runs the start/halt/done handshake with the testbench. All outputs are registered. The only combinational inputs from execute are `zero_i` and the decoder's `branch_i` and `halt_i`.

## Interface
- `PC_W`, 10: PC width in bits; the instruction address space is 2^PC_W.
- `LUT_AW`, 4: branch-LUT index width; the table depth is 2^LUT_AW.
- `START_ADDR`, 0: PC value loaded on reset and on `start`.
- `CNT_W`, 16: width of the run-cycle counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin execution at START_ADDR; one-cycle pulse.
- `stall_i`  in  1  downstream busy; freeze PC and counters this cycle.
- `branch_i`  in  1  current instruction is `beq`.
- `zero_i`  in  1  execute-stage equality flag for the current instruction.
- `halt_i`  in  1  current instruction is `halt`.
- `lut_idx_i`  in  LUT_AW  branch-target index carried by the current `beq`.
- `lut_we`  in  1  write enable for the branch LUT.
- `lut_waddr`  in  LUT_AW  LUT write index.
- `lut_wdata`  in  PC_W  LUT write data (absolute target PC).
- `pc_o`  out  PC_W  current fetch address.
- `running_o`  out  1  high in state RUN.
- `done_o`  out  1  high in state HALTED.
- `cycles_o`  out  CNT_W  number of non-stalled RUN cycles since the last start.
- `taken_o`  out  1  one-cycle pulse: the previous cycle's branch was taken.

## Operation
- States are IDLE, RUN and HALTED.
- Reset (`rst_n`=0 at an edge) takes priority over every other input:
  - state becomes IDLE and `pc_o` becomes START_ADDR;
  - `running_o`, `done_o` and `taken_o` become 0, and `cycles_o` becomes 0;
  - every LUT entry becomes 0.
- IDLE:
  - `start`=1 moves to RUN with `pc_o`=START_ADDR and `cycles_o`=0.
  - All other inputs are ignored except LUT writes.
- RUN, per cycle, in this priority order:
  1. `start`=1: restart. `pc_o` becomes START_ADDR, `cycles_o` becomes 0, state stays RUN. This overrides stall, halt and branch.
  2. `stall_i`=1: `pc_o` and `cycles_o` hold, `taken_o` becomes 0. Halt and branch are ignored because the instruction is re-presented on the next cycle.
  3. `halt_i`=1: go to HALTED with `pc_o` held and `cycles_o` incremented. Halt beats a simultaneous branch.
  4. `branch_i`=1 and `zero_i`=1: `pc_o` becomes LUT[`lut_idx_i`], `taken_o` becomes 1, `cycles_o` is incremented.
  5. Otherwise: `pc_o` becomes `pc_o`+1 modulo 2^PC_W (so 2^PC_W−1 wraps to 0), `taken_o` becomes 0, `cycles_o` is incremented.
- HALTED:
  - `done_o`=1 and all state holds.
  - `start`=1 moves to RUN with `pc_o`=START_ADDR, `cycles_o`=0 and `done_o` cleared.
- `cycles_o` saturates at 2^CNT_W−1 and does not wrap.
- LUT behaviour:
  - Writes are accepted in every state.
  - Reads are combinational from the stored array.
  - If a write and a branch read hit the same index in the same cycle, the branch uses the old entry; the new value is visible from the next cycle.
- `branch_i`=1 with `zero_i`=0 is a not-taken branch and follows the PC+1 path.

## Timing
- Latency:
  - `start` at edge N gives `pc_o`=START_ADDR and `running_o`=1 after edge N.
  - The decision made in cycle N shows on `pc_o` after edge N+1's sampling; that is one cycle, with no bubble on a taken branch.
- `zero_i`, `branch_i`, `halt_i` and `lut_idx_i` are sampled in the same cycle that `pc_o` presents the instruction (single-cycle datapath).
- `done_o` rises on the edge that samples `halt_i`. It stays high until `start` or reset.
- `taken_o` is valid for exactly one cycle after the taken edge.
- A reset asserted mid-RUN aborts immediately at that edge. No pending branch or halt is honoured.

## Test plan
- Reset, then `start` with no branches for 5 cycles: `pc_o` reads 0,1,2,3,4,5, `cycles_o`=5, `done_o`=0. Reset mid-sequence returns `pc_o`=0 and state IDLE.
- Load LUT[3]=0x120, run to PC 7, assert `branch_i`=1, `zero_i`=1, `lut_idx_i`=3: next `pc_o`=0x120 and `taken_o` pulses once. The same stimulus with `zero_i`=0 gives `pc_o`=8.
- Same-cycle LUT write of 0x055 to index 3 plus a taken branch via index 3: `pc_o`=0x120 (old value). A second taken branch via index 3 then gives 0x055.
- `halt_i`=1 together with a taken branch at PC 0x010: `done_o`=1 and `pc_o` stays 0x010. A subsequent `start` gives `pc_o`=0, `done_o`=0, `cycles_o`=0.
- Stall: `stall_i` held for 3 cycles at PC 4 with `branch_i`/`zero_i`/`halt_i` asserted gives `pc_o`=4 and `cycles_o` unchanged. After release the branch is taken once.
- Wrap and saturation:
  - With PC_W=4, run from 0xE for 3 cycles: `pc_o` reads E,F,0,1.
  - With CNT_W=3, run 10 cycles: `cycles_o` sticks at 7.
